// File: rtl/rv32_tb_package.sv
`default_nettype none
// ============================================================================
// Package     : rv32_tb_package
// Description : Retire-record type and sync-handshake states for the reporter.
// Revision    : 1.0 - initial release
// ============================================================================
package rv32_tb_package;

  localparam int RV32_XLEN = 32;

  typedef struct packed {
    logic [RV32_XLEN-1:0] pc;
    logic [4:0]           rd;
    logic [RV32_XLEN-1:0] data;
  } rv32_retire_t;

  typedef enum logic [1:0] {
    SYNC_IDLE    = 2'd0,
    SYNC_REQ     = 2'd1,
    SYNC_RELEASE = 2'd2
  } rv32_sync_state_t;

endpackage
`default_nettype wire

// File: rtl/rv32_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : rv32_sync_fifo
// Description : DEPTH-entry register FIFO of retire records; a push into a
//               full FIFO is accepted when a pop happens on the same edge.
// Revision    : 1.0 - initial release
// ============================================================================
module rv32_sync_fifo
  import rv32_tb_package::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  rv32_retire_t             wdata_i,
  output rv32_retire_t             rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);

  rv32_retire_t     mem_q [DEPTH];
  logic [PTR_W-1:0] head_q;
  logic [PTR_W-1:0] tail_q;
  logic [CNT_W-1:0] count_q;

  logic w_full;
  logic w_empty;
  logic w_do_pop;
  logic w_do_push;

  assign w_full    = (count_q == C_DEPTH);
  assign w_empty   = (count_q == '0);
  assign w_do_pop  = pop_i && !w_empty;
  // When full, the slot under the tail is the head being popped this edge.
  assign w_do_push = push_i && (!w_full || w_do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (w_do_push) begin
        tail_q <= tail_q + 1'b1;
      end
      if (w_do_pop) begin
        head_q <= head_q + 1'b1;
      end
      if (w_do_push && !w_do_pop) begin
        count_q <= count_q + 1'b1;
      end else if (w_do_pop && !w_do_push) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      mem_q[tail_q] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[head_q];
  assign full_o  = w_full;
  assign empty_o = w_empty;
  assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/rv32_retire_reporter.sv
`default_nettype none
// ============================================================================
// Module      : rv32_retire_reporter
// Description : Queues retired-instruction records and hands them to the
//               testbench one at a time over a four-phase req/ack handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module rv32_retire_reporter
  import rv32_tb_package::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    retire_valid_i,
  input  logic [XLEN-1:0]         retire_pc_i,
  input  logic [4:0]              retire_rd_i,
  input  logic [XLEN-1:0]         retire_data_i,
  output logic                    fifo_full_o,
  output logic                    overflow_o,
  output logic [$clog2(DEPTH):0]  count_o,
  output logic                    tb_req_o,
  output logic [XLEN-1:0]         tb_pc_o,
  output logic [4:0]              tb_rd_o,
  output logic [XLEN-1:0]         tb_data_o,
  input  logic                    tb_ack_i
);

  rv32_sync_state_t state_q;
  logic             tb_req_q;
  rv32_retire_t     tb_rec_q;
  logic             overflow_q;

  rv32_retire_t     w_wdata;
  rv32_retire_t     w_head;
  logic             w_full;
  logic             w_empty;
  logic             w_pop;
  logic             w_drop;

  assign w_wdata.pc   = retire_pc_i;
  assign w_wdata.rd   = retire_rd_i;
  assign w_wdata.data = retire_data_i;

  // A held-high ack (e.g. left over from a reset mid-handshake) blocks a new request.
  assign w_pop  = (state_q == SYNC_IDLE) && !w_empty && !tb_ack_i;
  assign w_drop = retire_valid_i && w_full && !w_pop;

  rv32_sync_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (retire_valid_i),
    .pop_i   (w_pop),
    .wdata_i (w_wdata),
    .rdata_o (w_head),
    .full_o  (w_full),
    .empty_o (w_empty),
    .count_o (count_o)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= SYNC_IDLE;
      tb_req_q   <= 1'b0;
      tb_rec_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (w_drop) begin
        overflow_q <= 1'b1;
      end
      unique case (state_q)
        SYNC_IDLE: begin
          if (w_pop) begin
            tb_rec_q <= w_head;
            tb_req_q <= 1'b1;
            state_q  <= SYNC_REQ;
          end
        end
        SYNC_REQ: begin
          if (tb_ack_i) begin
            tb_req_q <= 1'b0;
            state_q  <= SYNC_RELEASE;
          end
        end
        SYNC_RELEASE: begin
          if (!tb_ack_i) begin
            state_q <= SYNC_IDLE;
          end
        end
        default: begin
          state_q  <= SYNC_IDLE;
          tb_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign fifo_full_o = w_full;
  assign overflow_o  = overflow_q;
  assign tb_req_o    = tb_req_q;
  assign tb_pc_o     = tb_rec_q.pc;
  assign tb_rd_o     = tb_rec_q.rd;
  assign tb_data_o   = tb_rec_q.data;

endmodule
`default_nettype wire
